// File: rtl/multicycle_mem_responder.sv
// multicycle_mem_responder
// -------------------------
// Memory-side responder for a multi-cycle MIPS datapath. It holds one unified
// instruction/data word array and services the control unit's read/write
// strobes. Each accepted access spends WAIT_CYCLES wait states before a single
// response cycle. Completion is flagged by a one-cycle mem_ready pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mem_read   read strobe, held by the requester until mem_ready
//   mem_write  write strobe, held by the requester until mem_ready
//   addr       byte address (word aligned, below 4*DEPTH_WORDS)
//   wdata      write data
//   rdata      registered read data; holds the last completed read
//   mem_ready  one-cycle completion pulse, the cycle after RESP
//   busy       high while the FSM is not IDLE
//   addr_err   one-cycle pulse after a rejected request
`timescale 1ns/1ps

module multicycle_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              addr_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // The wait counter is 4 bits wide, so larger wait counts cannot be built.
  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("multicycle_mem_responder: WAIT_CYCLES must be in 0..15");
    end
    if (DEPTH_WORDS < 2 || DEPTH_WORDS > (1 << 29) ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("multicycle_mem_responder: DEPTH_WORDS must be a power of two in 2..2^29");
    end
  endgenerate

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // With no wait states the capture goes straight to the response cycle.
  localparam state_t ST_AFTER_CAPTURE = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_read_q, op_read_d;
  logic              mem_ready_q, mem_ready_d;
  logic              addr_err_q, addr_err_d;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_we, mem_re;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic req, req_ok;

  // Out of range means any address bit above the word index is set.
  always_comb begin
    req    = mem_read | mem_write;
    req_ok = (addr[1:0] == 2'b00) && (addr[31:AW+2] == '0) && !(mem_read && mem_write);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    op_read_d   = op_read_q;
    mem_ready_d = 1'b0;
    addr_err_d  = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (req_ok) begin
            idx_d     = addr[AW+1:2];
            wdata_d   = wdata;
            op_read_d = mem_read;
            cnt_d     = CNT_INIT;
            state_d   = ST_AFTER_CAPTURE;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Inputs are ignored here; the captured request is used.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        mem_ready_d = 1'b1;
        mem_re      = op_read_q;
        mem_we      = !op_read_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      op_read_q   <= 1'b0;
      mem_ready_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      op_read_q   <= op_read_d;
      mem_ready_q <= mem_ready_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Registered read port; the output register clears on reset but the array
  // itself is never initialised.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (mem_re) begin
      rdata_q <= mem[idx_q];
    end
  end

  // A reset landing on the RESP edge must keep a pending write out of the array.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign rdata     = rdata_q;
  assign mem_ready = mem_ready_q;
  assign addr_err  = addr_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multicycle_mem_responder.sv
`timescale 1ns/1ps

module tb_multicycle_mem_responder;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd2, wr2, rdy2, busy2, err2;
  logic [31:0] a2, d2, q2;
  logic        rd0, wr0, rdy0, busy0, err0;
  logic [31:0] a0, d0, q0;

  multicycle_mem_responder #(.DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_read(rd2), .mem_write(wr2), .addr(a2), .wdata(d2),
    .rdata(q2), .mem_ready(rdy2), .busy(busy2), .addr_err(err2));

  multicycle_mem_responder #(.DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .addr(a0), .wdata(d0),
    .rdata(q0), .mem_ready(rdy0), .busy(busy0), .addr_err(err0));

  int checks = 0;
  int errors = 0;

  // Reference model: word arrays per instance plus the expected rdata register.
  logic [31:0] mdl2 [int];
  logic [31:0] mdl0 [int];
  logic [31:0] exp2 = '0, exp0 = '0;
  bit          exp2_k = 1'b1, exp0_k = 1'b1;

  function automatic int wc(input int sel);
    return (sel == 0) ? 0 : 2;
  endfunction

  task automatic drive(input int sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin rd0 = rd; wr0 = wr; a0 = a; d0 = d; end
    else          begin rd2 = rd; wr2 = wr; a2 = a; d2 = d; end
  endtask

  task automatic sample(input int sel, output logic r, output logic b, output logic e, output logic [31:0] q);
    if (sel == 0) begin r = rdy0; b = busy0; e = err0; q = q0; end
    else          begin r = rdy2; b = busy2; e = err2; q = q2; end
  endtask

  // Behavioural model of one request: validity and the rdata seen at completion.
  task automatic model(input int sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output bit valid, output bit rv_k, output logic [31:0] rv);
    valid = (rd != wr) && (a % 4 == 0) && (a < 4 * DEPTH);
    rv    = (sel == 0) ? exp0 : exp2;
    rv_k  = (sel == 0) ? exp0_k : exp2_k;
    if (valid && wr) begin
      if (sel == 0) mdl0[int'(a / 4)] = d; else mdl2[int'(a / 4)] = d;
    end
    if (valid && rd) begin
      if (sel == 0) begin
        rv_k = mdl0.exists(int'(a / 4)); rv = rv_k ? mdl0[int'(a / 4)] : 'x; exp0 = rv; exp0_k = rv_k;
      end else begin
        rv_k = mdl2.exists(int'(a / 4)); rv = rv_k ? mdl2[int'(a / 4)] : 'x; exp2 = rv; exp2_k = rv_k;
      end
    end
  endtask

  // Drives one request, holds the strobe until mem_ready or addr_err (bounded),
  // then idles for 'post' cycles. Returns observations only.
  task automatic xact(input int sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input int post, output int lat, output int bcnt, output int ecnt, output int rcnt,
                      output int xcnt, output logic [31:0] rv, output logic [31:0] rafter);
    logic r, b, e;
    logic [31:0] q;
    bit done;
    lat = 0; bcnt = 0; ecnt = 0; rcnt = 0; xcnt = 0; rv = 'x; done = 1'b0;
    drive(sel, rd, wr, a, d);
    for (int k = 1; k <= 24 && !done; k++) begin
      @(posedge clk); @(negedge clk);
      sample(sel, r, b, e, q);
      if ($isunknown({r, b, e})) xcnt++;
      if (b === 1'b1) bcnt++;
      if (e === 1'b1) ecnt++;
      if (r === 1'b1) begin rcnt++; lat = k; rv = q; done = 1'b1; end
      else if (e === 1'b1) done = 1'b1;
    end
    drive(sel, 1'b0, 1'b0, a, d);
    q = rv;
    for (int k = 0; k < post; k++) begin
      @(posedge clk); @(negedge clk);
      sample(sel, r, b, e, q);
      if ($isunknown({r, b, e})) xcnt++;
      if (b === 1'b1) bcnt++;
      if (e === 1'b1) ecnt++;
      if (r === 1'b1) rcnt++;
    end
    if (post == 0) sample(sel, r, b, e, q);
    rafter = q;
    $display("xact W=%0d rd=%0b wr=%0b addr=%h wdata=%h lat=%0d busy=%0d err=%0d ready=%0d rdata=%h",
             wc(sel), rd, wr, a, d, lat, bcnt, ecnt, rcnt, rv);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0); drive(2, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({rdy2, busy2, err2} !== 3'b000) begin errors++; $display("FAIL reset_ctl_w2: got %b expected 000", {rdy2, busy2, err2}); end
    checks++; if (q2 !== 32'h0) begin errors++; $display("FAIL reset_rdata_w2: got %h expected 00000000", q2); end
    checks++; if ({rdy0, busy0, err0} !== 3'b000) begin errors++; $display("FAIL reset_ctl_w0: got %b expected 000", {rdy0, busy0, err0}); end
    checks++; if (q0 !== 32'h0) begin errors++; $display("FAIL reset_rdata_w0: got %h expected 00000000", q0); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({rdy2, busy2, err2, rdy0, busy0, err0} !== 6'b0) begin errors++; $display("FAIL reset_idle: got %b expected 000000", {rdy2, busy2, err2, rdy0, busy0, err0}); end
  endtask

  // Valid access on the W=2 instance with full latency/busy/data checks.
  task automatic test_valid_access(input string nm, input bit rd, input logic [31:0] a, input logic [31:0] d);
    bit v, k; logic [31:0] e, rv, ra; int lat, bc, ec, rc, xc;
    model(2, rd, !rd, a, d, v, k, e);
    xact(2, rd, !rd, a, d, 1, lat, bc, ec, rc, xc, rv, ra);
    checks++; if (lat !== 4) begin errors++; $display("FAIL %s latency: got %0d expected 4", nm, lat); end
    checks++; if (bc !== 3) begin errors++; $display("FAIL %s busy_cycles: got %0d expected 3", nm, bc); end
    checks++; if (rc !== 1 || ec !== 0 || xc !== 0) begin errors++; $display("FAIL %s pulses: got ready=%0d err=%0d x=%0d expected 1 0 0", nm, rc, ec, xc); end
    if (k) begin
      checks++; if (rv !== e) begin errors++; $display("FAIL %s rdata: got %h expected %h", nm, rv, e); end
      checks++; if (ra !== e) begin errors++; $display("FAIL %s rdata_hold: got %h expected %h", nm, ra, e); end
    end
  endtask

  task automatic test_write_read;
    test_valid_access("write_10", 1'b0, 32'h10, 32'hDEADBEEF);
    test_valid_access("read_10", 1'b1, 32'h10, 32'h0);
    test_valid_access("read_14_unwritten", 1'b1, 32'h14, 32'h0);
    test_valid_access("reread_10", 1'b1, 32'h10, 32'h0);
  endtask

  task automatic test_addr_err;
    logic [31:0] bad [3];
    bit v, k; logic [31:0] e, rv, ra; int lat, bc, ec, rc, xc;
    bad[0] = 32'h12; bad[1] = 32'(4 * DEPTH); bad[2] = 32'h8000_0010;
    for (int i = 0; i < 3; i++) begin
      model(2, 1'b1, 1'b0, bad[i], '0, v, k, e);
      xact(2, 1'b1, 1'b0, bad[i], '0, 2, lat, bc, ec, rc, xc, rv, ra);
      checks++; if (ec !== 1) begin errors++; $display("FAIL addr_err_pulse %h: got %0d expected 1", bad[i], ec); end
      checks++; if (rc !== 0 || bc !== 0) begin errors++; $display("FAIL addr_err_quiet %h: got ready=%0d busy=%0d expected 0 0", bad[i], rc, bc); end
      checks++; if (ra !== e) begin errors++; $display("FAIL addr_err_rdata %h: got %h expected %h", bad[i], ra, e); end
    end
  endtask

  task automatic test_both_strobes;
    bit v, k; logic [31:0] e, rv, ra; int lat, bc, ec, rc, xc;
    test_valid_access("write_20", 1'b0, 32'h20, 32'hA5A5_5A5A);
    model(2, 1'b1, 1'b1, 32'h20, 32'h1, v, k, e);
    xact(2, 1'b1, 1'b1, 32'h20, 32'h1, 1, lat, bc, ec, rc, xc, rv, ra);
    checks++; if (ec !== 1 || rc !== 0) begin errors++; $display("FAIL both_strobes: got err=%0d ready=%0d expected 1 0", ec, rc); end
    test_valid_access("read_20_after_conflict", 1'b1, 32'h20, 32'h0);
  endtask

  // Reset during WAIT (dly 1,2) and during RESP (dly 3): pending write is lost.
  task automatic test_reset_mid;
    int rc;
    test_valid_access("write_30", 1'b0, 32'h30, 32'h0BAD_F00D);
    for (int dly = 1; dly <= 3; dly++) begin
      drive(2, 1'b0, 1'b1, 32'h30, 32'h1234_5678 + 32'(dly));
      repeat (dly) begin @(posedge clk); @(negedge clk); end
      checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL reset_mid_busy d%0d: got %b expected 1", dly, busy2); end
      rst = 1'b1;
      drive(2, 1'b0, 1'b0, '0, '0);
      @(posedge clk); @(negedge clk);
      checks++; if ({rdy2, busy2, err2, q2} !== 35'b0) begin errors++; $display("FAIL reset_mid_outputs d%0d: got %b %h expected all zero", dly, {rdy2, busy2, err2}, q2); end
      rst = 1'b0;
      exp2 = '0; exp2_k = 1'b1; exp0 = '0; exp0_k = 1'b1;
      rc = 0;
      repeat (6) begin @(posedge clk); @(negedge clk); if (rdy2 !== 1'b0) rc++; end
      checks++; if (rc !== 0) begin errors++; $display("FAIL reset_mid_no_ready d%0d: got %0d pulses expected 0", dly, rc); end
      test_valid_access("read_30_after_abort", 1'b1, 32'h30, 32'h0);
    end
  endtask

  task automatic test_wait0_back_to_back;
    logic [31:0] vals [2];
    bit v, k; logic [31:0] e, rv, ra; int lat, bc, ec, rc, xc;
    vals[0] = $urandom; vals[1] = $urandom;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 2; i++) begin
        model(0, pass == 1, pass == 0, 32'(4 * i), vals[i], v, k, e);
        xact(0, pass == 1, pass == 0, 32'(4 * i), vals[i], 1, lat, bc, ec, rc, xc, rv, ra);
        checks++; if (lat !== 2 || bc !== 1) begin errors++; $display("FAIL w0_timing a%0d: got lat=%0d busy=%0d expected 2 1", 4 * i, lat, bc); end
        checks++; if (rc !== 1 || ec !== 0) begin errors++; $display("FAIL w0_pulses a%0d: got ready=%0d err=%0d expected 1 0", 4 * i, rc, ec); end
        checks++; if (rv !== e) begin errors++; $display("FAIL w0_rdata a%0d: got %h expected %h", 4 * i, rv, e); end
      end
    end
  endtask

  task automatic test_random;
    bit v, k, rd, wr; logic [31:0] a, d, e, rv, ra; int lat, bc, ec, rc, xc, sel, kind, post;
    for (int n = 0; n < 80; n++) begin
      sel  = ($urandom_range(0, 1) == 0) ? 0 : 2;
      kind = $urandom_range(0, 9);
      post = $urandom_range(0, 2);
      a    = 32'($urandom_range(0, 15) * 4);
      d    = $urandom;
      rd   = $urandom_range(0, 1) == 1;
      wr   = !rd;
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) begin a = $urandom & 32'hFFFF_FFFC; if (a < 4 * DEPTH) a = a + 32'(4 * DEPTH); end
      else if (kind == 2) begin rd = 1'b1; wr = 1'b1; end
      model(sel, rd, wr, a, d, v, k, e);
      xact(sel, rd, wr, a, d, post, lat, bc, ec, rc, xc, rv, ra);
      checks++; if (rc !== (v ? 1 : 0) || ec !== (v ? 0 : 1) || xc !== 0) begin
        errors++; $display("FAIL rand%0d pulses: got ready=%0d err=%0d x=%0d expected %0d %0d 0", n, rc, ec, xc, v ? 1 : 0, v ? 0 : 1); end
      checks++; if (lat !== (v ? wc(sel) + 2 : 0) || bc !== (v ? wc(sel) + 1 : 0)) begin
        errors++; $display("FAIL rand%0d timing: got lat=%0d busy=%0d expected %0d %0d", n, lat, bc, v ? wc(sel) + 2 : 0, v ? wc(sel) + 1 : 0); end
      if (k) begin
        checks++; if (ra !== e || (v && rv !== e)) begin errors++; $display("FAIL rand%0d rdata: got %h/%h expected %h", n, rv, ra, e); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_write_read();
    test_addr_err();
    test_both_strobes();
    test_reset_mid();
    test_wait0_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
